// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux path.
// Registered one-hot grant, mux select and busy, with a hold limit.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_d;
  logic [1:0] sel_d;
  logic       busy_d;

  logic [3:0] own_oh;
  logic [3:0] others;
  logic [2:0] pick_all;
  logic [2:0] pick_oth;
  logic       expire;
  logic       take;
  logic [1:0] take_idx;

  // {found, index}: first requester after p, wrapping back to p last
  function automatic logic [2:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = p + 2'(i);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign own_oh   = 4'b0001 << owner_q;
  assign others   = req & ~own_oh;
  assign pick_all = rr_pick(req, ptr_q);
  assign pick_oth = rr_pick(others, ptr_q);
  assign expire   = (cnt_q == 8'(MAX_HOLD - 1));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt;
    sel_d    = sel;
    busy_d   = busy;
    take     = 1'b0;
    take_idx = 2'd0;
    unique case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          take     = 1'b1;
          take_idx = pick_all[1:0];
        end else begin
          gnt_d  = 4'b0000;
          busy_d = 1'b0;
        end
      end
      OWN: begin
        unique case (1'b1)
          !req[owner_q]: begin
            if (pick_oth[2]) begin
              take     = 1'b1;
              take_idx = pick_oth[1:0];
            end else begin
              state_d = IDLE;
              gnt_d   = 4'b0000;
              busy_d  = 1'b0;
            end
          end
          req[owner_q] && expire: begin
            if (pick_oth[2]) begin
              take     = 1'b1;
              take_idx = pick_oth[1:0];
            end else begin
              cnt_d = 8'd0;
            end
          end
          default: cnt_d = cnt_q + 8'd1;
        endcase
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = OWN;
      owner_d = take_idx;
      ptr_d   = take_idx;
      cnt_d   = 8'd0;
      gnt_d   = 4'b0001 << take_idx;
      sel_d   = take_idx;
      busy_d  = 1'b1;
    end
  end

  // ptr resets to 3 so requester 0 is first in line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= 8'd0;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter (MAX_HOLD = 4).
// Driver queues expected outputs; a forked monitor pops and checks.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  typedef struct {
    logic [3:0]  g;
    logic [1:0]  s;
    logic        b;
    logic [63:0] tag;
  } exp_t;

  exp_t q[$];
  int   total;
  int   bad;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input logic        rn,
    input logic [3:0]  r,
    input logic [3:0]  eg,
    input logic [1:0]  es,
    input logic        eb,
    input logic [63:0] tag
  );
    exp_t e;
    rst_n = rn;
    req   = r;
    @(posedge clk);
    e.g   = eg;
    e.s   = es;
    e.b   = eb;
    e.tag = tag;
    q.push_back(e);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'b0000;

    fork
      forever begin
        @(negedge clk);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          total++;
          if (gnt !== e.g || sel !== e.s || busy !== e.b) begin
            bad++;
            $display("FAIL %s: got gnt=%b sel=%0d busy=%b want gnt=%b sel=%0d busy=%b",
                     e.tag, gnt, sel, busy, e.g, e.s, e.b);
          end
        end
      end
    join_none

    #1;
    // reset then single request
    step(0, 4'b0000, 4'b0000, 2'd0, 0, "reset");
    step(0, 4'b0000, 4'b0000, 2'd0, 0, "reset");
    step(1, 4'b0100, 4'b0100, 2'd2, 1, "single");
    step(1, 4'b0000, 4'b0000, 2'd2, 0, "release");

    // fairness: each owner drops for one cycle after service
    step(0, 4'b0000, 4'b0000, 2'd0, 0, "reset");
    step(1, 4'b1111, 4'b0001, 2'd0, 1, "fair0");
    step(1, 4'b1110, 4'b0010, 2'd1, 1, "fair1");
    step(1, 4'b1101, 4'b0100, 2'd2, 1, "fair2");
    step(1, 4'b1011, 4'b1000, 2'd3, 1, "fair3");
    step(1, 4'b0111, 4'b0001, 2'd0, 1, "fair0b");
    step(1, 4'b0000, 4'b0000, 2'd0, 0, "fairidl");

    // hold limit with two contenders
    step(0, 4'b0000, 4'b0000, 2'd0, 0, "reset");
    for (int i = 0; i < 4; i++)
      step(1, 4'b0011, 4'b0001, 2'd0, 1, "hold0");
    for (int i = 0; i < 4; i++)
      step(1, 4'b0011, 4'b0010, 2'd1, 1, "hold1");
    for (int i = 0; i < 4; i++)
      step(1, 4'b0011, 4'b0001, 2'd0, 1, "hold0b");
    step(1, 4'b0000, 4'b0000, 2'd0, 0, "holdidl");

    // lone owner keeps the path past the limit
    for (int i = 0; i < 20; i++)
      step(1, 4'b1000, 4'b1000, 2'd3, 1, "lone");
    step(1, 4'b0000, 4'b0000, 2'd3, 0, "loneidl");

    // release coincides with hold expiry
    for (int i = 0; i < 4; i++)
      step(1, 4'b0011, 4'b0001, 2'd0, 1, "coin0");
    step(1, 4'b0010, 4'b0010, 2'd1, 1, "coin1");
    step(1, 4'b0010, 4'b0010, 2'd1, 1, "coin1b");
    step(1, 4'b0000, 4'b0000, 2'd1, 0, "coinidl");

    // reset in the middle of a grant
    step(1, 4'b0100, 4'b0100, 2'd2, 1, "mid2");
    step(0, 4'b1111, 4'b0000, 2'd0, 0, "midrst");
    step(1, 4'b1111, 4'b0001, 2'd0, 1, "midpost");
    step(1, 4'b0000, 4'b0000, 2'd0, 0, "mididl");

    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
